uart_ram_bridge: RTL and testbench
==================================

Name: uart_ram_bridge

Overview:
- Block mode engine that moves data between the board UART (byte-wide, sharing the RAM1 data bus low byte) and RAM2 (16-bit SRAM).
- LOAD mode receives bytes from the UART, packs them into 16-bit words and writes them to RAM2.
- DUMP mode reads RAM2 words and transmits them as bytes over the UART.
- Sits beside the machine switcher on the board clock as the next selectable machine. It drives UART strobes and RAM2 control, and parks RAM1 while it owns the shared bus.

Parameters:
- STROBE_CYCLES, 2, width in clk cycles of every rdn, wrn and ram_we low pulse, and of the ram_oe read wait (≥1).
- TIMEOUT_CYCLES, 0, max cycles to wait on data_ready or tbre/tsre before aborting with err; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse that begins a transfer; sampled only in IDLE
- mode  in  1  0 = LOAD (UART→RAM2), 1 = DUMP (RAM2→UART)
- base_addr  in  18  first RAM2 word address
- word_count  in  16  number of 16-bit words to transfer
- data_ready  in  1  UART receive byte available
- tbre  in  1  UART transmit buffer empty
- tsre  in  1  UART transmit shift register empty
- uart_din  in  8  shared bus low byte, read side
- uart_dout  out  8  byte to transmit
- uart_dout_oe  out  1  drive uart_dout onto the shared bus
- rdn  out  1  UART read strobe, active-low
- wrn  out  1  UART write strobe, active-low
- ram1_en  out  1  RAM1 chip enable, active-low; held 1 (parked)
- ram_addr  out  18  RAM2 address
- ram_din  in  16  RAM2 data, read side
- ram_dout  out  16  RAM2 write data
- ram_dout_oe  out  1  drive ram_dout onto the RAM2 bus
- ram_en  out  1  RAM2 chip enable, active-low
- ram_oe  out  1  RAM2 output enable, active-low
- ram_we  out  1  RAM2 write enable, active-low
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on timeout abort
- words_done  out  16  words completed in the current or last transfer

Behaviour:
- Reset values: rdn=wrn=ram_oe=ram_we=ram_en=ram1_en=1, all oe outputs 0, busy=done=err=0, words_done=0, ram_addr=0, uart_dout=0, ram_dout=0.
- Reset mid-operation: all strobes return high at the next edge. No partial word is written.
- All outputs are registered. Strobes therefore change only on clk edges.
- States:
  - IDLE: on start, latch base_addr into ram_addr, load the word counter, clear words_done, set busy. If word_count==0, pulse done the next cycle, stay in IDLE and leave busy low after that cycle. Otherwise go to RX_WAIT (LOAD) or RD_SETUP (DUMP).
  - RX_WAIT: wait for data_ready=1, then go to RX_PULSE.
  - RX_PULSE: rdn=0 for STROBE_CYCLES. Sample uart_din on the last low cycle, then rdn=1.
    - The first byte of a word goes to ram_dout[7:0] (low byte first); the second goes to ram_dout[15:8].
    - After the first byte, go back to RX_WAIT. After the second, go to WR_SETUP.
  - WR_SETUP (1 cycle): ram_en=0, ram_oe=1, ram_dout_oe=1.
  - WR_PULSE: ram_we=0 for STROBE_CYCLES.
  - WR_HOLD (1 cycle): ram_we=1 with data still driven. Then ram_dout_oe=0, ram_addr+1, words_done+1.
  - RD_SETUP: ram_en=0, ram_oe=0 for STROBE_CYCLES. Latch ram_din on the last cycle, then ram_oe=1.
  - TX_WAIT: wait for tbre=1 and tsre=1.
  - TX_PULSE: uart_dout_oe=1 and wrn=0 for STROBE_CYCLES, then wrn=1 and uart_dout_oe=0.
    - Sends the low byte first, then returns to TX_WAIT for the high byte.
    - After the high byte: ram_addr+1, words_done+1, then go to RD_SETUP.
- Completion: when words_done reaches word_count, pulse done, clear busy, go to IDLE, and set ram_en=1.
- ram_addr wraps modulo 2^18.
- The RAM2 bus and the UART bus are never driven in the same cycle. ram_dout_oe and uart_dout_oe are mutually exclusive.
- In any state, rdn and wrn are never both low.
- Timeout (TIMEOUT_CYCLES>0): a wait counter resets on entry to RX_WAIT or TX_WAIT. If it reaches TIMEOUT_CYCLES, pulse err, clear busy, return to IDLE and release all strobes. words_done keeps the count of completed words.
- start while busy is ignored. Inputs are re-latched only from IDLE.

Test Plan:
- Reset during a WR_PULSE with ram_we low → all strobes high at the next edge, busy=0, words_done=0.
- LOAD base_addr=0x00010, word_count=2, UART bytes 0x34,0x12,0x78,0x56 → RAM2[0x10]=0x1234, RAM2[0x11]=0x5678. Each ram_we low exactly STROBE_CYCLES. done pulses once, words_done=2.
- DUMP base_addr=0x3FFFF, word_count=2, RAM2[0x3FFFF]=0xBEEF, RAM2[0]=0xCAFE → UART bytes EF,BE,FE,CA. ram_addr wraps to 0.
- word_count=0 with start → done pulses next cycle, no strobe ever goes low.
- TIMEOUT_CYCLES=50, LOAD word_count=3 with only 2 bytes sent → err pulses about 50 cycles after the last byte, words_done=1, busy=0.
- DUMP with tsre held 0 for 20 cycles after tbre=1 → wrn stays high until tsre=1. A start pulse during the transfer is ignored.

Source files
------------

// File: rtl/uart_ram_bridge.sv
// Block-mode engine between the board UART and RAM2: LOAD packs received bytes
// into 16-bit words written to RAM2, DUMP reads RAM2 words and sends them as bytes.
module uart_ram_bridge #(
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [17:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    input  logic [7:0]  uart_din,
    output logic [7:0]  uart_dout,
    output logic        uart_dout_oe,
    output logic        rdn,
    output logic        wrn,
    output logic        ram1_en,
    output logic [17:0] ram_addr,
    input  logic [15:0] ram_din,
    output logic [15:0] ram_dout,
    output logic        ram_dout_oe,
    output logic        ram_en,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_done
);

    typedef enum logic [3:0] {
        IDLE, RX_WAIT, RX_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, TX_WAIT, TX_PULSE
    } state_e;

    typedef struct packed {
        state_e      state;
        logic [15:0] cnt;
        logic [31:0] wait_cnt;
        logic        hi_byte;
        logic [15:0] total;
        logic [15:0] tx_word;
        logic [7:0]  uart_dout;
        logic        uart_dout_oe;
        logic        rdn;
        logic        wrn;
        logic [17:0] ram_addr;
        logic [15:0] ram_dout;
        logic        ram_dout_oe;
        logic        ram_en;
        logic        ram_oe;
        logic        ram_we;
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] words_done;
    } regs_t;

    localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    localparam regs_t REGS_RESET = '{
        state: IDLE, cnt: '0, wait_cnt: '0, hi_byte: 1'b0, total: '0, tx_word: '0,
        uart_dout: '0, uart_dout_oe: 1'b0, rdn: 1'b1, wrn: 1'b1, ram_addr: '0,
        ram_dout: '0, ram_dout_oe: 1'b0, ram_en: 1'b1, ram_oe: 1'b1, ram_we: 1'b1,
        busy: 1'b0, done: 1'b0, err: 1'b0, words_done: '0
    };

    regs_t r_q, r_d;
    logic  strobe_last, last_word, timed_out, abort;

    assign strobe_last = (r_q.cnt == STROBE_LAST);
    assign last_word   = (r_q.words_done + 16'd1 == r_q.total);
    assign timed_out   = (TIMEOUT_CYCLES != 0) && (r_q.wait_cnt == TIMEOUT_LAST);

    // NOTE: next-state logic uses blocking '=' and starts from r_q, so every
    // field has a value on every path and no latch can be inferred.
    always_comb begin
        r_d          = r_q;
        abort        = 1'b0;
        r_d.done     = 1'b0;
        r_d.err      = 1'b0;
        r_d.cnt      = r_q.cnt + 16'd1;
        r_d.wait_cnt = r_q.wait_cnt + 32'd1;
        case (r_q.state)
            IDLE: begin
                if (start) begin
                    r_d.ram_addr   = base_addr;
                    r_d.total      = word_count;
                    r_d.words_done = '0;
                    r_d.hi_byte    = 1'b0;
                    if (word_count == 16'd0) begin
                        r_d.done = 1'b1;
                    end else if (mode) begin
                        r_d.busy   = 1'b1;
                        r_d.state  = RD_SETUP;
                        r_d.ram_en = 1'b0;
                        r_d.ram_oe = 1'b0;
                        r_d.cnt    = '0;
                    end else begin
                        r_d.busy     = 1'b1;
                        r_d.state    = RX_WAIT;
                        r_d.wait_cnt = '0;
                    end
                end
            end
            RX_WAIT: begin
                if (data_ready) begin
                    r_d.state = RX_PULSE;
                    r_d.rdn   = 1'b0;
                    r_d.cnt   = '0;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            RX_PULSE: begin
                if (strobe_last) begin
                    r_d.rdn = 1'b1;
                    if (!r_q.hi_byte) begin
                        r_d.ram_dout[7:0] = uart_din;
                        r_d.hi_byte       = 1'b1;
                        r_d.state         = RX_WAIT;
                        r_d.wait_cnt      = '0;
                    end else begin
                        r_d.ram_dout[15:8] = uart_din;
                        r_d.hi_byte        = 1'b0;
                        r_d.state          = WR_SETUP;
                        r_d.ram_en         = 1'b0;
                        r_d.ram_oe         = 1'b1;
                        r_d.ram_dout_oe    = 1'b1;
                    end
                end
            end
            WR_SETUP: begin
                r_d.state  = WR_PULSE;
                r_d.ram_we = 1'b0;
                r_d.cnt    = '0;
            end
            WR_PULSE: begin
                if (strobe_last) begin
                    r_d.ram_we = 1'b1;
                    r_d.state  = WR_HOLD;
                end
            end
            WR_HOLD: begin
                r_d.ram_dout_oe = 1'b0;
                r_d.ram_addr    = r_q.ram_addr + 18'd1;
                r_d.words_done  = r_q.words_done + 16'd1;
                r_d.state       = RX_WAIT;
                r_d.wait_cnt    = '0;
            end
            RD_SETUP: begin
                if (strobe_last) begin
                    r_d.tx_word  = ram_din;
                    r_d.ram_oe   = 1'b1;
                    r_d.state    = TX_WAIT;
                    r_d.wait_cnt = '0;
                end
            end
            TX_WAIT: begin
                if (tbre && tsre) begin
                    r_d.state        = TX_PULSE;
                    r_d.uart_dout    = r_q.hi_byte ? r_q.tx_word[15:8] : r_q.tx_word[7:0];
                    r_d.uart_dout_oe = 1'b1;
                    r_d.wrn          = 1'b0;
                    r_d.cnt          = '0;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            TX_PULSE: begin
                if (strobe_last) begin
                    r_d.wrn          = 1'b1;
                    r_d.uart_dout_oe = 1'b0;
                    if (!r_q.hi_byte) begin
                        r_d.hi_byte  = 1'b1;
                        r_d.state    = TX_WAIT;
                        r_d.wait_cnt = '0;
                    end else begin
                        r_d.hi_byte    = 1'b0;
                        r_d.ram_addr   = r_q.ram_addr + 18'd1;
                        r_d.words_done = r_q.words_done + 16'd1;
                        r_d.state      = RD_SETUP;
                        r_d.ram_oe     = 1'b0;
                        r_d.cnt        = '0;
                    end
                end
            end
            default: r_d = REGS_RESET;
        endcase

        // A finished word that was the last one ends the transfer instead.
        if ((r_q.state == WR_HOLD || (r_q.state == TX_PULSE && strobe_last && r_q.hi_byte))
                && last_word) begin
            r_d.state  = IDLE;
            r_d.ram_oe = 1'b1;
            r_d.ram_en = 1'b1;
            r_d.busy   = 1'b0;
            r_d.done   = 1'b1;
        end

        if (abort) begin
            r_d.state        = IDLE;
            r_d.rdn          = 1'b1;
            r_d.wrn          = 1'b1;
            r_d.ram_we       = 1'b1;
            r_d.ram_oe       = 1'b1;
            r_d.ram_en       = 1'b1;
            r_d.uart_dout_oe = 1'b0;
            r_d.ram_dout_oe  = 1'b0;
            r_d.hi_byte      = 1'b0;
            r_d.busy         = 1'b0;
            r_d.err          = 1'b1;
        end
    end

    // NOTE: the whole register set, data included, is reset so a reset in the
    // middle of a transfer releases every strobe and drops any partial word.
    always_ff @(posedge clk) begin
        if (rst) r_q <= REGS_RESET;
        else     r_q <= r_d;
    end

    assign uart_dout    = r_q.uart_dout;
    assign uart_dout_oe = r_q.uart_dout_oe;
    assign rdn          = r_q.rdn;
    assign wrn          = r_q.wrn;
    assign ram1_en      = 1'b1;
    assign ram_addr     = r_q.ram_addr;
    assign ram_dout     = r_q.ram_dout;
    assign ram_dout_oe  = r_q.ram_dout_oe;
    assign ram_en       = r_q.ram_en;
    assign ram_oe       = r_q.ram_oe;
    assign ram_we       = r_q.ram_we;
    assign busy         = r_q.busy;
    assign done         = r_q.done;
    assign err          = r_q.err;
    assign words_done   = r_q.words_done;

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Self-checking bench for uart_ram_bridge: behavioural RAM2 and UART models,
// directed scenarios plus randomized LOAD/DUMP round trips.
module tb_uart_ram_bridge;

    localparam int S  = 2;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst, start, mode, data_ready, tbre, tsre;
    logic [17:0] base_addr;
    logic [15:0] word_count;
    logic [7:0]  uart_din, uart_dout;
    logic        uart_dout_oe, rdn, wrn, ram1_en, ram_dout_oe, ram_en, ram_oe, ram_we;
    logic [17:0] ram_addr;
    logic [15:0] ram_din, ram_dout, words_done;
    logic        busy, done, err;

    always #5 clk = ~clk;

    uart_ram_bridge #(.STROBE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .word_count(word_count), .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
        .uart_din(uart_din), .uart_dout(uart_dout), .uart_dout_oe(uart_dout_oe),
        .rdn(rdn), .wrn(wrn), .ram1_en(ram1_en), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_dout_oe(ram_dout_oe), .ram_en(ram_en), .ram_oe(ram_oe),
        .ram_we(ram_we), .busy(busy), .done(done), .err(err), .words_done(words_done)
    );

    int checks = 0;
    int errors = 0;

    // RAM2 model: a word is committed when ram_we rises (unless reset cut the pulse).
    logic [15:0] mem [262144];
    logic        poke_en = 1'b0;
    logic [17:0] poke_addr;
    logic [15:0] poke_data;
    assign ram_din = (!ram_en && !ram_oe) ? mem[ram_addr] : 16'h0000;

    int          viol = 0, done_cnt = 0, err_cnt = 0, low_cycles = 0, we_pulses = 0;
    int          run [4];
    logic [3:0]  prev_s = 4'hF;
    logic        prev_rst = 1'b0, tx_ok_prev = 1'b0;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  tx_q [$];
    logic [17:0] rd_q [$];

    always @(negedge clk) begin
        logic [3:0] s;
        s = {rdn, wrn, ram_we, ram_oe};
        if (poke_en) mem[poke_addr] = poke_data;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (s != 4'hF) low_cycles++;
        if (!rdn && !wrn) viol++;
        if (ram_dout_oe && uart_dout_oe) viol++;
        if (ram_dout_oe && !ram_oe) viol++;
        if (ram1_en !== 1'b1) viol++;
        for (int i = 0; i < 4; i++) begin
            if (rst) run[i] = 0;
            else if (!s[i]) run[i]++;
            else begin
                if (run[i] != 0 && run[i] != S) viol++;
                run[i] = 0;
            end
        end
        if (!ram_we) begin
            wr_addr = ram_addr;
            wr_data = ram_dout;
            if (!ram_dout_oe || ram_en) viol++;
        end
        if (!prev_s[1] && ram_we && !prev_rst) begin
            mem[wr_addr] = wr_data;
            we_pulses++;
            if (!ram_dout_oe) viol++;
        end
        if (prev_s[0] && !ram_oe) rd_q.push_back(ram_addr);
        if (prev_s[2] && !wrn) begin
            tx_q.push_back(uart_dout);
            if (!uart_dout_oe || !tx_ok_prev) viol++;
        end
        tx_ok_prev = tbre && tsre;
        prev_s     = s;
        prev_rst   = rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [15:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        tick(1);
        poke_en   = 1'b0;
    endtask

    task automatic start_xfer(input logic m, input logic [17:0] b, input logic [15:0] wc);
        mode       = m;
        base_addr  = b;
        word_count = wc;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap);
        int n = 0;
        tick(gap);
        uart_din   = b;
        data_ready = 1'b1;
        while (rdn !== 1'b0 && n < 200) begin tick(1); n++; end
        while (rdn !== 1'b1 && n < 200) begin tick(1); n++; end
        data_ready = 1'b0;
        check("rx_handshake_bounded", 32'(n < 200), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 2000) begin tick(1); n++; end
        check({tag, "_bounded"}, 32'(n < 2000), 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, {rdn, wrn, ram_we, ram_oe, ram_en, ram1_en,
                               uart_dout_oe, ram_dout_oe, busy, done, err}, 11'b111111_00000);
        check({tag, "_words_done"}, words_done, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_data"}, {uart_dout, ram_dout}, 0);
    endtask

    initial begin
        int          d0, e0, w0, l0, t0, r0, n;
        logic [17:0] b;
        int          wc;
        logic [7:0]  bytes_q [$];

        rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; word_count = '0;
        data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1; uart_din = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_state("reset");

        // Directed LOAD: two words, low byte first.
        d0 = done_cnt; w0 = we_pulses;
        start_xfer(1'b0, 18'h00010, 16'd2);
        check("load_busy", busy, 1);
        rx_byte(8'h34, 0); rx_byte(8'h12, 2); rx_byte(8'h78, 1); rx_byte(8'h56, 3);
        wait_idle("load");
        check("load_done_pulse", done, 1);
        tick(2);
        check("load_mem0", mem[18'h10], 16'h1234);
        check("load_mem1", mem[18'h11], 16'h5678);
        check("load_done_count", done_cnt - d0, 1);
        check("load_we_pulses", we_pulses - w0, 2);
        check("load_words_done", words_done, 2);
        check("load_idle", {busy, ram_en, ram_dout_oe}, 3'b010);

        // Directed DUMP across the top of the address space.
        poke(18'h3FFFF, 16'hBEEF);
        poke(18'h00000, 16'hCAFE);
        t0 = tx_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        start_xfer(1'b1, 18'h3FFFF, 16'd2);
        wait_idle("dump_wrap");
        tick(2);
        check("dump_tx_count", tx_q.size() - t0, 4);
        if (tx_q.size() >= t0 + 4) begin
            check("dump_tx0", tx_q[t0],     8'hEF);
            check("dump_tx1", tx_q[t0 + 1], 8'hBE);
            check("dump_tx2", tx_q[t0 + 2], 8'hFE);
            check("dump_tx3", tx_q[t0 + 3], 8'hCA);
        end
        check("dump_rd_count", rd_q.size() - r0, 2);
        if (rd_q.size() >= r0 + 2) begin
            check("dump_rd_addr0", rd_q[r0],     18'h3FFFF);
            check("dump_rd_addr1", rd_q[r0 + 1], 18'h00000);
        end
        check("dump_final_addr", ram_addr, 18'h00001);
        check("dump_done_count", done_cnt - d0, 1);

        // Zero-length transfer.
        l0 = low_cycles; d0 = done_cnt;
        start_xfer(1'b0, 18'h00123, 16'd0);
        check("zero_done_next", done, 1);
        tick(1);
        check("zero_done_cleared", {done, busy}, 2'b00);
        tick(5);
        check("zero_no_strobes", low_cycles - l0, 0);
        check("zero_done_count", done_cnt - d0, 1);

        // Timeout: three words requested, only two bytes arrive.
        e0 = err_cnt;
        start_xfer(1'b0, 18'h00200, 16'd3);
        rx_byte(8'hAA, 0); rx_byte(8'h55, 0);
        n = 0;
        while (err !== 1'b1 && n < 200) begin tick(1); n++; end
        check("timeout_latency_window", 32'(n >= TO && n <= TO + 10), 1);
        check("timeout_words_done", words_done, 1);
        check("timeout_busy", busy, 0);
        check("timeout_strobes", {rdn, wrn, ram_we, ram_oe, ram_en}, 5'h1F);
        tick(2);
        check("timeout_err_count", err_cnt - e0, 1);
        check("timeout_mem", mem[18'h200], 16'h55AA);

        // tsre held low: no write strobe until it rises; a second start is ignored.
        poke(18'h00300, 16'hA1B2);
        poke(18'h00301, 16'hC3D4);
        tbre = 1'b1; tsre = 1'b0;
        t0 = tx_q.size(); d0 = done_cnt;
        start_xfer(1'b1, 18'h00300, 16'd2);
        tick(8);
        start_xfer(1'b0, 18'h00100, 16'd5);
        tick(11);
        check("tsre_no_tx", tx_q.size() - t0, 0);
        check("tsre_wrn_high", wrn, 1);
        tsre = 1'b1;
        wait_idle("tsre");
        tick(10);
        check("tsre_tx_count", tx_q.size() - t0, 4);
        if (tx_q.size() >= t0 + 4)
            check("tsre_tx_bytes", {tx_q[t0], tx_q[t0 + 1], tx_q[t0 + 2], tx_q[t0 + 3]},
                  32'hB2A1_D4C3);
        check("tsre_words_done", words_done, 2);
        check("tsre_final_addr", ram_addr, 18'h00302);
        check("tsre_single_done", done_cnt - d0, 1);
        check("tsre_stays_idle", busy, 0);

        // Reset while ram_we is low on the second word.
        start_xfer(1'b0, 18'h00040, 16'd2);
        rx_byte(8'h01, 0); rx_byte(8'h02, 0); rx_byte(8'h03, 0); rx_byte(8'h04, 0);
        n = 0;
        while (ram_we !== 1'b0 && n < 20) begin tick(1); n++; end
        check("reset_we_low_reached", 32'(n < 20), 1);
        check("reset_pre_words_done", words_done, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_state("midop_reset");

        // Randomized LOAD then DUMP round trips; the byte stream must come back unchanged.
        for (int r = 0; r < 3; r++) begin
            bytes_q.delete();
            b  = ($urandom_range(0, 1) != 0) ? 18'h3FFFE : 18'($urandom);
            wc = $urandom_range(1, 4);
            for (int i = 0; i < 2 * wc; i++) bytes_q.push_back(8'($urandom));
            start_xfer(1'b0, b, 16'(wc));
            foreach (bytes_q[i]) rx_byte(bytes_q[i], $urandom_range(0, 5));
            wait_idle("rand_load");
            tick(2);
            check("rand_load_words", words_done, 32'(wc));
            for (int i = 0; i < wc; i++)
                check("rand_mem", mem[18'(b + 18'(i))], {bytes_q[2 * i + 1], bytes_q[2 * i]});
            t0 = tx_q.size();
            start_xfer(1'b1, b, 16'(wc));
            wait_idle("rand_dump");
            tick(2);
            check("rand_tx_count", tx_q.size() - t0, 32'(2 * wc));
            for (int i = 0; i < 2 * wc; i++)
                if (t0 + i < tx_q.size()) check("rand_tx_byte", tx_q[t0 + i], bytes_q[i]);
        end

        check("protocol_violations", viol, 0);
        check("total_err_pulses", err_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
